// File: rtl/priority_decoder_12b.sv
// priority_decoder_12b
//   Inverse of the 12-request priority encoder. A request index arrives over a
//   valid/ready handshake. The matching one-hot line is driven for HOLD_CYCLES
//   clock cycles and then released. NONE_CODE is accepted and ignored. Any
//   other out-of-range code is accepted and flagged with a one-cycle err pulse.
//
//   Optional feature macro: DECODER_HISTORY_EN
//     When defined, the hist port holds a sticky OR of every legal line that
//     has been decoded since reset. When undefined, the port and register are
//     absent.
//
// Ports
//   clk       in   1      system clock, rising edge
//   reset_n   in   1      synchronous reset, active-low
//   in_valid  in   1      in_code is valid this cycle
//   in_ready  out  1      block can accept a code this cycle (IDLE)
//   in_code   in   IDX_W  request index to decode
//   onehot    out  WIDTH  decoded output, at most one bit high
//   busy      out  1      a pulse is being held
//   err       out  1      one-cycle pulse: illegal code accepted
//   hist      out  WIDTH  sticky decode history (DECODER_HISTORY_EN only)

module priority_decoder_12b #(
  parameter int unsigned WIDTH       = 12,
  parameter int unsigned IDX_W       = 4,
  parameter int unsigned HOLD_CYCLES = 4,
  parameter int unsigned NONE_CODE   = 15
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IDX_W-1:0] in_code,
  output logic [WIDTH-1:0] onehot,
  output logic             busy,
  output logic             err
`ifdef DECODER_HISTORY_EN
  ,
  output logic [WIDTH-1:0] hist
`endif
);

  // Counter sized for HOLD_CYCLES-1; at least one bit so HOLD_CYCLES=1 works.
  localparam int unsigned      CNT_W    = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [IDX_W-1:0] WIDTH_C  = IDX_W'(WIDTH);
  localparam logic [IDX_W-1:0] NONE_C   = IDX_W'(NONE_CODE);

  typedef enum logic {
    IDLE,
    HOLD
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] onehot_q, onehot_d;
  logic             busy_q, busy_d;
  logic             err_q, err_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic             xfer;
  logic             code_legal;
  logic             code_none;
  logic [WIDTH-1:0] dec;

  // Ready is a pure state decode, so there is no path from in_valid.
  assign in_ready   = (state_q == IDLE);
  assign xfer       = in_valid && in_ready;
  assign code_legal = (in_code < WIDTH_C);
  assign code_none  = (in_code == NONE_C);

  always_comb begin
    dec = '0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      dec[i] = (in_code == IDX_W'(i));
    end
  end

  always_comb begin
    state_d  = state_q;
    onehot_d = onehot_q;
    busy_d   = busy_q;
    cnt_d    = cnt_q;
    err_d    = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (xfer) begin
          if (code_legal) begin
            onehot_d = dec;
            cnt_d    = CNT_LOAD;
            busy_d   = 1'b1;
            state_d  = HOLD;
          end else if (!code_none) begin
            err_d = 1'b1;
          end
        end
      end
      HOLD: begin
        // The cycle with cnt==0 is the last held cycle; release on its edge.
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else begin
          onehot_d = '0;
          busy_d   = 1'b0;
          state_d  = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      onehot_q <= '0;
      busy_q   <= 1'b0;
      err_q    <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      onehot_q <= onehot_d;
      busy_q   <= busy_d;
      err_q    <= err_d;
      cnt_q    <= cnt_d;
    end
  end

  assign onehot = onehot_q;
  assign busy   = busy_q;
  assign err    = err_q;

`ifdef DECODER_HISTORY_EN
  logic [WIDTH-1:0] hist_q, hist_d;

  always_comb begin
    hist_d = hist_q;
    if (xfer && code_legal) begin
      hist_d = hist_q | dec;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      hist_q <= '0;
    end else begin
      hist_q <= hist_d;
    end
  end

  assign hist = hist_q;
`endif

endmodule

// File: tb/tb_priority_decoder_12b.sv
module tb_priority_decoder_12b;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [3:0]  in_code = 4'd0;
  logic [11:0] onehot;
  logic        busy;
  logic        err;
`ifdef DECODER_HISTORY_EN
  logic [11:0] hist;
`endif

  priority_decoder_12b #(
    .WIDTH(12),
    .IDX_W(4),
    .HOLD_CYCLES(4),
    .NONE_CODE(15)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_code(in_code),
    .onehot(onehot),
    .busy(busy),
    .err(err)
`ifdef DECODER_HISTORY_EN
    ,
    .hist(hist)
`endif
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    bit          is_err;
    logic [11:0] val;
    int unsigned len;
    int unsigned start;
  } ev_t;

  ev_t exp_q[$];
  int  errors = 0;
  int  checks = 0;
  bit  mon_en = 1'b0;

  logic [11:0] cur_val = '0;
  int unsigned cur_len = 0;
  int unsigned cur_start = 0;

  task automatic check(input bit ok, input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  function automatic void push(input bit is_err, input logic [11:0] v, input int unsigned len, input int unsigned start);
    ev_t e;
    e.is_err = is_err;
    e.val    = v;
    e.len    = len;
    e.start  = start;
    exp_q.push_back(e);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic close_pulse();
    ev_t e;
    if (exp_q.size() == 0) begin
      check(1'b0, "unexpected_pulse", cur_val, 0);
    end else begin
      e = exp_q.pop_front();
      check(!e.is_err, "event_kind_pulse", 1, {31'd0, e.is_err});
      check(cur_val == e.val, "pulse_value", cur_val, e.val);
      check(cur_len == e.len, "pulse_len", cur_len, e.len);
      check(cur_start == e.start, "pulse_start", cur_start, e.start);
    end
    cur_val = '0;
  endtask

  task automatic see_err();
    ev_t e;
    if (exp_q.size() == 0) begin
      check(1'b0, "unexpected_err", 1, 0);
    end else begin
      e = exp_q.pop_front();
      check(e.is_err, "event_kind_err", 0, 1);
      check(cyc == e.start, "err_cycle", cyc, e.start);
      check(onehot == '0, "err_onehot", onehot, 0);
    end
  endtask

  // Monitor: samples on the falling edge, tracks pulses and err strobes and
  // compares each completed event with the head of the expected queue.
  always @(negedge clk) begin
    if (mon_en) begin
      check(in_ready == (onehot == '0), "ready_vs_idle", {31'd0, in_ready}, {31'd0, onehot == '0});
      check(busy == (onehot != '0), "busy_vs_pulse", {31'd0, busy}, {31'd0, onehot != '0});
      if (cur_val != '0 && onehot != cur_val) close_pulse();
      if (onehot != '0 && cur_val == '0) begin
        cur_val   = onehot;
        cur_len   = 1;
        cur_start = cyc;
      end else if (onehot != '0) begin
        cur_len++;
      end
      if (err) see_err();
    end
  end

  task automatic send_legal(input logic [3:0] code, input logic [11:0] expv);
    in_code  = code;
    in_valid = 1'b1;
    push(1'b0, expv, 4, cyc + 1);
    tick();
    in_valid = 1'b0;
    repeat (4) tick();
  endtask

  int unsigned n;

  initial begin
    // 1: reset held with a valid request present
    in_valid = 1'b1;
    in_code  = 4'd5;
    repeat (3) tick();
    check(onehot == '0, "reset_onehot", onehot, 0);
    check(busy == 1'b0, "reset_busy", busy, 0);
    check(err == 1'b0, "reset_err", err, 0);
`ifdef DECODER_HISTORY_EN
    check(hist == '0, "reset_hist", hist, 0);
`endif
    reset_n  = 1'b1;
    in_valid = 1'b0;
    tick();
    check(in_ready == 1'b1, "ready_after_reset", in_ready, 1);
    mon_en = 1'b1;
    tick();

    // 2: single legal decode of the top line
    send_legal(4'd11, 12'h800);
    tick();

    // 3: back-to-back with valid held high
    n = cyc;
    push(1'b0, 12'h001, 4, n + 1);
    push(1'b0, 12'h080, 4, n + 6);
    in_code  = 4'd0;
    in_valid = 1'b1;
    tick();
    in_code = 4'd7;
    repeat (5) tick();
    in_valid = 1'b0;
    repeat (5) tick();

    // 4: none code, then two illegal codes on consecutive edges
    in_code  = 4'd15;
    in_valid = 1'b1;
    tick();
    in_code = 4'd12;
    push(1'b1, '0, 1, cyc + 1);
    tick();
    in_code = 4'd14;
    push(1'b1, '0, 1, cyc + 1);
    tick();
    in_valid = 1'b0;
    repeat (2) tick();

    // 5: reset during the second hold cycle abandons the pulse
    in_code  = 4'd3;
    in_valid = 1'b1;
    push(1'b0, 12'h008, 2, cyc + 1);
    tick();
    in_valid = 1'b0;
    tick();
    reset_n = 1'b0;
    tick();
    check(onehot == '0, "midhold_reset_onehot", onehot, 0);
    check(busy == 1'b0, "midhold_reset_busy", busy, 0);
    reset_n = 1'b1;
    tick();
    send_legal(4'd4, 12'h010);
    tick();

    // 6: history accumulation (decodes run in every build)
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
`ifdef DECODER_HISTORY_EN
    check(hist == '0, "hist_cleared", hist, 0);
`endif
    tick();
    send_legal(4'd2, 12'h004);
    send_legal(4'd9, 12'h200);
`ifdef DECODER_HISTORY_EN
    check(hist == 12'h204, "hist_2_9", hist, 12'h204);
`endif
    in_code  = 4'd15;
    in_valid = 1'b1;
    tick();
    in_code = 4'd13;
    push(1'b1, '0, 1, cyc + 1);
    tick();
    in_valid = 1'b0;
    tick();
`ifdef DECODER_HISTORY_EN
    check(hist == 12'h204, "hist_after_none_illegal", hist, 12'h204);
`endif
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
`ifdef DECODER_HISTORY_EN
    check(hist == '0, "hist_reset", hist, 0);
`endif
    repeat (3) tick();

    check(exp_q.size() == 0, "queue_drained", exp_q.size(), 0);
    check(cur_val == '0, "no_open_pulse", cur_val, 0);
    mon_en = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
